// File: rtl/ballot_input_ctrl.sv
// ============================================================================
//  Module   : ballot_input_ctrl
//  Purpose  : Voter button front end for the vote counter. Synchronises and
//             debounces P1/P2/P3/NOTA and issues at most one vote pulse per
//             ballot released by the presiding officer.
//  Options  : define BALLOT_TIMEOUT_EN to let an armed ballot expire after
//             TIMEOUT_CYCLES clocks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ballot_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic CLK,
    input  logic CLEAR_N,
    input  logic BTN_P1,
    input  logic BTN_P2,
    input  logic BTN_P3,
    input  logic BTN_NOTA,
    input  logic BALLOT_ISSUE,
    output logic P1_VOTE,
    output logic P2_VOTE,
    output logic P3_VOTE,
    output logic NOTA_VOTE,
    output logic READY,
    output logic MULTI_ERR,
    output logic TIMEOUT
);

    localparam int             c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAST    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    generate
        if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("ballot_input_ctrl: DEBOUNCE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    // Bit order throughout: 0=P1, 1=P2, 2=P3, 3=NOTA
    logic [3:0] w_btn_raw;
    logic [3:0] w_level;
    logic [3:0] r_level_d;
    logic [3:0] r_press;
    logic [2:0] w_new;
    logic [1:0] w_press_idx;

    assign w_btn_raw = {BTN_NOTA, BTN_P3, BTN_P2, BTN_P1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic              r_sync1;
            logic              r_sync2;
            logic              r_lvl;
            logic [c_DB_W-1:0] r_cnt;
            logic [c_DB_W-1:0] w_cnt_inc;

            assign w_cnt_inc = (r_cnt == c_DB_MAX) ? r_cnt : r_cnt + c_DB_W'(1);

            always_ff @(posedge CLK or negedge CLEAR_N) begin
                if (!CLEAR_N) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == c_DB_MAX) begin
                        // Restart from zero so a bounce right after the
                        // toggle must again persist for the full window.
                        r_lvl <= ~r_lvl;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
            end

            assign w_level[gi] = r_lvl;
        end
    endgenerate

    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_level_d <= '0;
            r_press   <= '0;
        end else begin
            r_level_d <= w_level;
            r_press   <= w_level & ~r_level_d;
        end
    end

    assign w_new = {2'b00, r_press[0]} + {2'b00, r_press[1]}
                 + {2'b00, r_press[2]} + {2'b00, r_press[3]};

    always_comb begin
        w_press_idx = 2'd0;
        if (r_press[1]) w_press_idx = 2'd1;
        if (r_press[2]) w_press_idx = 2'd2;
        if (r_press[3]) w_press_idx = 2'd3;
    end

    logic r_issue_d;
    logic w_issue_rise;

    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) r_issue_d <= 1'b0;
        else          r_issue_d <= BALLOT_ISSUE;
    end

    assign w_issue_rise = BALLOT_ISSUE & ~r_issue_d;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_idx;
    logic [1:0] w_idx_next;
    logic       r_consumed;
    logic       w_consumed_next;
    logic       w_multi_evt;
    logic       w_timeout_evt;
    logic       w_to_expire;

`ifdef BALLOT_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_to_cnt;

    assign w_to_expire = (r_state == S_ARMED) &&
                         (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));

    // Cleared only in IDLE, so time spent armed before a rejected
    // multi-press still counts once the ballot is re-armed.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_to_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_to_cnt <= '0;
        end else if (r_state == S_ARMED && !w_to_expire) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end
`else
    assign w_to_expire = 1'b0;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_consumed_next = r_consumed;
        w_multi_evt     = 1'b0;
        w_timeout_evt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue_rise) begin
                    w_consumed_next = 1'b0;
                    w_state_next    = (|w_level) ? S_RELEASE : S_ARMED;
                end
            end
            S_ARMED: begin
                if (w_new == 3'd1) begin
                    w_idx_next   = w_press_idx;
                    w_state_next = S_CAST;
                end else if (w_new > 3'd1) begin
                    w_multi_evt  = 1'b1;
                    w_state_next = S_RELEASE;
                end else if (w_to_expire) begin
                    w_timeout_evt   = 1'b1;
                    w_consumed_next = 1'b1;
                    w_state_next    = S_RELEASE;
                end
            end
            S_CAST: begin
                w_consumed_next = 1'b1;
                w_state_next    = S_RELEASE;
            end
            S_RELEASE: begin
                if (!(|w_level)) begin
                    w_state_next = r_consumed ? S_IDLE : S_ARMED;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    logic [3:0] r_vote;
    logic       r_ready;
    logic       r_multi_err;
    logic       r_timeout;

    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_consumed  <= 1'b0;
            r_vote      <= '0;
            r_ready     <= 1'b0;
            r_multi_err <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_consumed  <= w_consumed_next;
            r_vote      <= (r_state == S_CAST) ? (4'b0001 << r_idx) : 4'b0000;
            r_ready     <= (r_state == S_ARMED);
            r_multi_err <= w_multi_evt;
            r_timeout   <= w_timeout_evt;
        end
    end

    assign P1_VOTE   = r_vote[0];
    assign P2_VOTE   = r_vote[1];
    assign P3_VOTE   = r_vote[2];
    assign NOTA_VOTE = r_vote[3];
    assign READY     = r_ready;
    assign MULTI_ERR = r_multi_err;
    assign TIMEOUT   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_ballot_input_ctrl.sv
// ============================================================================
//  Module   : tb_ballot_input_ctrl
//  Purpose  : Self-checking bench for ballot_input_ctrl (DEBOUNCE_CYCLES=4,
//             TIMEOUT_CYCLES=32); honours BALLOT_TIMEOUT_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ballot_input_ctrl;

    logic CLK = 1'b0;
    logic CLEAR_N = 1'b0;
    logic BTN_P1 = 1'b0;
    logic BTN_P2 = 1'b0;
    logic BTN_P3 = 1'b0;
    logic BTN_NOTA = 1'b0;
    logic BALLOT_ISSUE = 1'b0;
    logic P1_VOTE, P2_VOTE, P3_VOTE, NOTA_VOTE, READY, MULTI_ERR, TIMEOUT;

    ballot_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .CLK         (CLK),
        .CLEAR_N     (CLEAR_N),
        .BTN_P1      (BTN_P1),
        .BTN_P2      (BTN_P2),
        .BTN_P3      (BTN_P3),
        .BTN_NOTA    (BTN_NOTA),
        .BALLOT_ISSUE(BALLOT_ISSUE),
        .P1_VOTE     (P1_VOTE),
        .P2_VOTE     (P2_VOTE),
        .P3_VOTE     (P3_VOTE),
        .NOTA_VOTE   (NOTA_VOTE),
        .READY       (READY),
        .MULTI_ERR   (MULTI_ERR),
        .TIMEOUT     (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Pulse tallies: 0..3 votes P1/P2/P3/NOTA, 4 MULTI_ERR, 5 TIMEOUT
    int pulses[6];
    int overlap;
    int snap[6];
    int n_checks;
    int n_fail;

    initial begin
        for (int i = 0; i < 6; i++) pulses[i] = 0;
        overlap = 0;
    end

    always @(negedge CLK) begin
        if (P1_VOTE)   pulses[0]++;
        if (P2_VOTE)   pulses[1]++;
        if (P3_VOTE)   pulses[2]++;
        if (NOTA_VOTE) pulses[3]++;
        if (MULTI_ERR) pulses[4]++;
        if (TIMEOUT)   pulses[5]++;
        if ($countones({P1_VOTE, P2_VOTE, P3_VOTE, NOTA_VOTE}) > 1) overlap++;
    end

    typedef struct {
        logic [3:0] btns;
        int         hold;
        logic [3:0] exp_vote;
        int         exp_multi;
        int         exp_ready;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] m);
        {BTN_NOTA, BTN_P3, BTN_P2, BTN_P1} = m;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        set_btns(m);
        tick(hold);
        set_btns(4'b0000);
    endtask

    task automatic issue_ballot();
        BALLOT_ISSUE = 1'b1;
        tick(1);
        BALLOT_ISSUE = 1'b0;
        tick(1);
    endtask

    task automatic take_snap();
        for (int i = 0; i < 6; i++) snap[i] = pulses[i];
    endtask

    function automatic int delta(input int i);
        return pulses[i] - snap[i];
    endfunction

    function automatic int votes_delta();
        return delta(0) + delta(1) + delta(2) + delta(3);
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{4'b0001, 12, 4'b0001, 0, 0};
        vecs[1] = '{4'b0010, 12, 4'b0010, 0, 0};
        vecs[2] = '{4'b0100, 12, 4'b0100, 0, 0};
        vecs[3] = '{4'b1000, 12, 4'b1000, 0, 0};
        vecs[4] = '{4'b1001, 12, 4'b0000, 1, 1};
        vecs[5] = '{4'b0110, 12, 4'b0000, 1, 1};
        vecs[6] = '{4'b1111, 12, 4'b0000, 1, 1};
        vecs[7] = '{4'b0100,  3, 4'b0000, 0, 1};

        // Reset state
        tick(3);
        chk("reset_outputs",
            {25'd0, P1_VOTE, P2_VOTE, P3_VOTE, NOTA_VOTE, READY, MULTI_ERR, TIMEOUT}, 0);
        CLEAR_N = 1'b1;
        tick(2);

        // Exact vote latency: press sampled at edge 0, vote high after edge 8
        issue_ballot();
        chk("t1_ready", READY, 1);
        take_snap();
        set_btns(4'b0010);
        tick(8);
        chk("t1_p2_before", P2_VOTE, 0);
        tick(1);
        chk("t1_p2_at8", P2_VOTE, 1);
        chk("t1_ready_after", READY, 0);
        tick(1);
        chk("t1_p2_after", P2_VOTE, 0);
        tick(10);
        set_btns(4'b0000);
        tick(12);
        chk("t1_p2_count", delta(1), 1);
        chk("t1_idle_ready", READY, 0);

        // Table-driven single and multi presses
        for (int r = 0; r < 8; r++) begin
            take_snap();
            issue_ballot();
            press(vecs[r].btns, vecs[r].hold);
            tick(12);
            for (int i = 0; i < 4; i++)
                chk($sformatf("row%0d_vote%0d", r, i), delta(i), int'(vecs[r].exp_vote[i]));
            chk($sformatf("row%0d_multi", r), delta(4), vecs[r].exp_multi);
            chk($sformatf("row%0d_ready", r), READY, vecs[r].exp_ready);
            if (vecs[r].exp_ready != 0) begin
                press(4'b0001, 12);
                tick(12);
            end
        end

        // Bounce on P1 while armed
        issue_ballot();
        take_snap();
        set_btns(4'b0001); tick(1);
        set_btns(4'b0000); tick(1);
        set_btns(4'b0001); tick(1);
        set_btns(4'b0000); tick(5);
        chk("t2_no_bounce_vote", votes_delta(), 0);
        press(4'b0001, 12);
        tick(12);
        chk("t2_p1_once", delta(0), 1);
        chk("t2_total_votes", votes_delta(), 1);

        // Simultaneous P1+NOTA, then P3 on the same ballot
        issue_ballot();
        take_snap();
        set_btns(4'b1001);
        tick(12);
        chk("t3_multi", delta(4), 1);
        chk("t3_no_vote", votes_delta(), 0);
        chk("t3_not_ready_held", READY, 0);
        set_btns(4'b0000);
        tick(12);
        chk("t3_rearmed", READY, 1);
        press(4'b0100, 12);
        tick(12);
        chk("t3_p3", delta(2), 1);
        chk("t3_total_votes", votes_delta(), 1);

        // NOTA held across ballot issue
        set_btns(4'b1000);
        tick(10);
        take_snap();
        issue_ballot();
        tick(10);
        chk("t4_held_not_ready", READY, 0);
        chk("t4_held_no_vote", votes_delta(), 0);
        set_btns(4'b0000);
        tick(12);
        chk("t4_ready_after_release", READY, 1);
        press(4'b1000, 12);
        tick(12);
        chk("t4_nota_once", delta(3), 1);
        chk("t4_total_votes", votes_delta(), 1);
        chk("t4_idle", READY, 0);

        // Presses without a ballot are discarded; second issue is not queued
        take_snap();
        for (int k = 0; k < 5; k++) begin
            press(4'b0001, 8);
            tick(10);
        end
        chk("t5_idle_presses", votes_delta(), 0);
        take_snap();
        issue_ballot();
        tick(2);
        issue_ballot();
        press(4'b0001, 12);
        tick(12);
        chk("t5_one_vote", delta(0), 1);
        chk("t5_no_queued_ballot", READY, 0);
        press(4'b0010, 12);
        tick(12);
        chk("t5_total_votes", votes_delta(), 1);

`ifdef BALLOT_TIMEOUT_EN
        // Ballot expiry
        take_snap();
        issue_ballot();
        tick(40);
        chk("t6_timeout_pulse", delta(5), 1);
        chk("t6_not_ready", READY, 0);
        press(4'b0001, 12);
        tick(12);
        chk("t6_no_vote_after_timeout", votes_delta(), 0);
`else
        chk("t6_timeout_tied_low", pulses[5], 0);
`endif

        // Reset in the middle of the vote pulse
        issue_ballot();
        set_btns(4'b0010);
        tick(9);
        chk("t7_p2_high", P2_VOTE, 1);
        CLEAR_N = 1'b0;
        #1;
        chk("t7_cleared_outputs",
            {25'd0, P1_VOTE, P2_VOTE, P3_VOTE, NOTA_VOTE, READY, MULTI_ERR, TIMEOUT}, 0);
        tick(2);
        CLEAR_N = 1'b1;
        set_btns(4'b0000);
        tick(12);
        take_snap();
        press(4'b0010, 12);
        tick(12);
        chk("t7_ballot_lost", votes_delta(), 0);

        chk("never_two_votes", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
